// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: walks a register table and writes each entry over a byte-level I2C master,
// with NACK retry, sticky error reporting, table re-run and runtime single-register writes.
module i2c_reg_seq #(
   parameter int CLK_FREQ = 50000000,
   parameter int I2C_FREQ = 20000,
   parameter logic [7:0] DEV_ADDR = 8'hBA,
   parameter int REG_AW = 8,
   parameter int DATA_W = 16,
   parameter int LUT_SIZE = 26,
   parameter int MAX_RETRY = 3,
   parameter int STARTUP_WAIT = 1000000,
   localparam int IW = (LUT_SIZE > 1) ? $clog2(LUT_SIZE) : 1
) (
   input  logic                     iCLK,
   input  logic                     iRST,
   input  logic                     iSTART,
   input  logic                     iWR_REQ,
   input  logic [REG_AW-1:0]        iWR_ADDR,
   input  logic [DATA_W-1:0]        iWR_DATA,
   output logic                     oWR_ACK,
   output logic [IW-1:0]            oLUT_IDX,
   input  logic [REG_AW+DATA_W-1:0] iLUT_ENTRY,
   output logic                     oBUSY,
   output logic                     oDONE,
   output logic                     oERR,
   output logic [IW-1:0]            oERR_IDX,
   output logic                     I2C_SCLK,
   inout  wire                      I2C_SDAT
);
   localparam int Q = CLK_FREQ / (4 * I2C_FREQ);
   localparam int TW = $clog2(Q + 1);
   localparam int FW = 8 + REG_AW + DATA_W;
   localparam int N = FW / 8;
   localparam int BW = $clog2(N);
   localparam int WW = $clog2(STARTUP_WAIT + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);
   localparam logic [IW-1:0] LAST = IW'(LUT_SIZE - 1);
   typedef enum logic [2:0] {WAIT, IDLE, LOAD, START, SHIFT, ACK, STOP, NEXT} state_t;
   state_t state, state_n;
   logic [TW-1:0] tcnt;
   logic [WW-1:0] wcnt;
   logic [1:0] ph;
   logic [2:0] bc;
   logic [BW-1:0] byc;
   logic [FW-1:0] sh, fr;
   logic [RW-1:0] retry;
   logic nack, rt, sda_o, tick, end_bit, bit_st, wait_done, run_go;
   assign I2C_SDAT = sda_o ? 1'bz : 1'b0;
   assign tick = tcnt == TW'(Q - 1);
   assign end_bit = tick && ph == 2'd3;
   assign bit_st = state inside {START, SHIFT, ACK, STOP};
   assign wait_done = wcnt == WW'(STARTUP_WAIT - 1);
   assign run_go = (state == WAIT && wait_done) || (state == IDLE && iSTART);
   always_ff @(posedge iCLK) tcnt <= (iRST || tick) ? '0 : tcnt + 1'b1;
   always_ff @(posedge iCLK) state <= iRST ? WAIT : state_n;
   // oWR_ACK blocks the still-held request for the one cycle before the requester drops it
   always_comb begin
      state_n = state;
      case (state)
         WAIT:  state_n = wait_done ? LOAD : WAIT;
         IDLE:  state_n = (iSTART || (iWR_REQ && !oWR_ACK)) ? LOAD : IDLE;
         LOAD:  state_n = START;
         START: state_n = end_bit ? SHIFT : START;
         SHIFT: state_n = (end_bit && bc == 3'd7) ? ACK : SHIFT;
         ACK:   state_n = end_bit ? ((nack || byc == BW'(N - 1)) ? STOP : SHIFT) : ACK;
         STOP:  state_n = end_bit ? ((nack && retry < RW'(MAX_RETRY)) ? START : NEXT) : STOP;
         NEXT:  state_n = (rt || oLUT_IDX == LAST) ? IDLE : LOAD;
      endcase
   end
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         wcnt <= '0; ph <= '0; bc <= '0; byc <= '0; sh <= '0; fr <= '0; retry <= '0;
         nack <= 1'b0; rt <= 1'b0; oLUT_IDX <= '0; oDONE <= 1'b0; oERR <= 1'b0; oERR_IDX <= '0;
         oWR_ACK <= 1'b0; oBUSY <= 1'b0; I2C_SCLK <= 1'b1; sda_o <= 1'b1;
      end else begin
         oWR_ACK <= 1'b0;
         oBUSY <= state_n != IDLE;
         ph <= bit_st ? ph + {1'b0, tick} : 2'd0;
         if (state == WAIT) wcnt <= wcnt + 1'b1;
         if (run_go) begin
            oLUT_IDX <= '0; oDONE <= 1'b0; oERR <= 1'b0; rt <= 1'b0;
         end
         if (state == IDLE && !iSTART && iWR_REQ && !oWR_ACK) rt <= 1'b1;
         if (state == LOAD) begin
            fr <= rt ? {DEV_ADDR, iWR_ADDR, iWR_DATA} : {DEV_ADDR, iLUT_ENTRY};
            retry <= '0;
         end
         if (state == NEXT) begin
            if (nack) oERR <= 1'b1;
            if (nack && !oERR && !rt) oERR_IDX <= oLUT_IDX;
            if (rt) oWR_ACK <= 1'b1;
            else if (oLUT_IDX == LAST) oDONE <= 1'b1;
            else oLUT_IDX <= oLUT_IDX + 1'b1;
         end
         // phase 0 sets up SDA with SCL low, 1-2 hold SCL high, 3 drops SCL
         if (tick) case (state)
            START: begin
               I2C_SCLK <= ph != 2'd3;
               sda_o <= !ph[1];
               sh <= fr; bc <= '0; byc <= '0; nack <= 1'b0;
            end
            SHIFT: begin
               I2C_SCLK <= ph[0] ^ ph[1];
               if (ph == 2'd0) sda_o <= sh[FW-1];
               if (ph == 2'd3) begin
                  sh <= sh << 1; bc <= bc + 3'd1;
               end
            end
            ACK: begin
               I2C_SCLK <= ph[0] ^ ph[1];
               sda_o <= 1'b1;
               if (ph == 2'd2) nack <= I2C_SDAT;
               if (ph == 2'd3) byc <= byc + 1'b1;
            end
            STOP: begin
               I2C_SCLK <= ph != 2'd0;
               sda_o <= ph[1];
               if (ph == 2'd3 && nack) retry <= retry + 1'b1;
            end
            default: ;
         endcase
      end
   end
endmodule
